// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared widths and arbiter state type for the framebuffer arbiter
package fb_pkg;
   localparam int AW     = 16;
   localparam int DW     = 8;
   localparam int WAIT_W = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RESP = 2'd1,
      DONE = 2'd2
   } arb_state_t;
endpackage

// File: rtl/fb_pixel_pipe.sv
// rtl/fb_pixel_pipe.sv - display pixel stage: RAM read data qualified by last cycle's fetch
module fb_pixel_pipe #(
   parameter int DW = fb_pkg::DW
) (
   input  logic          vga_clk,
   input  logic          rst,
   input  logic          vga_fetch,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] pix_data,
   output logic          pix_valid
);

   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         pix_valid <= 1'b0;
      end else begin
         pix_valid <= vga_fetch;
      end
   end

   // RAM already adds the cycle of latency; blank to black when nothing was fetched
   assign pix_data = pix_valid ? mem_rdata : '0;

endmodule

// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - single-port framebuffer shared by display fetch (priority) and processor
module framebuffer_arbiter #(
   parameter int AW     = fb_pkg::AW,
   parameter int DW     = fb_pkg::DW,
   parameter int WAIT_W = fb_pkg::WAIT_W
) (
   input  logic              vga_clk,
   input  logic              rst,
   input  logic              vga_fetch,
   input  logic [AW-1:0]     vga_addr,
   output logic [DW-1:0]     pix_data,
   output logic              pix_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [AW-1:0]     cpu_addr,
   input  logic [DW-1:0]     cpu_wdata,
   output logic              cpu_ack,
   output logic [DW-1:0]     cpu_rdata,
   output logic [WAIT_W-1:0] cpu_wait,
   output logic [AW-1:0]     mem_addr,
   output logic              mem_we,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata
);
   import fb_pkg::*;

   arb_state_t        state, state_nxt;
   logic              issue;
   logic              is_read_q;
   logic [DW-1:0]     rdata_q;
   logic [WAIT_W-1:0] wait_q;

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req && !vga_fetch) begin
               issue     = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Reset gates the write strobe directly so a held cpu_req cannot write during reset
   always_comb begin
      mem_addr  = vga_addr;
      mem_we    = 1'b0;
      mem_wdata = cpu_wdata;
      if (issue && !rst) begin
         mem_addr = cpu_addr;
         mem_we   = cpu_we;
      end
   end

   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         is_read_q <= 1'b0;
         rdata_q   <= '0;
         wait_q    <= '0;
      end else begin
         state <= state_nxt;
         if (issue) begin
            is_read_q <= !cpu_we;
         end
         if (state == RESP && is_read_q) begin
            rdata_q <= mem_rdata;
         end
         if (state == RESP || (state == IDLE && !cpu_req)) begin
            wait_q <= '0;
         end else if (state == IDLE && cpu_req && vga_fetch && wait_q != '1) begin
            wait_q <= wait_q + 1'b1;
         end
      end
   end

   // Read data is live on the RAM port during the ack cycle, then held until the next ack
   assign cpu_ack   = (state == RESP);
   assign cpu_rdata = (cpu_ack && is_read_q) ? mem_rdata : rdata_q;
   assign cpu_wait  = wait_q;

   fb_pixel_pipe #(.DW(DW)) u_pixel_pipe (
      .vga_clk   (vga_clk),
      .rst       (rst),
      .vga_fetch (vga_fetch),
      .mem_rdata (mem_rdata),
      .pix_data  (pix_data),
      .pix_valid (pix_valid)
   );

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb/tb_framebuffer_arbiter.sv - scoreboard bench for framebuffer_arbiter with a behavioural RAM
module tb_framebuffer_arbiter;

   logic        vga_clk = 1'b0;
   logic        rst;
   logic        vga_fetch;
   logic [15:0] vga_addr;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic [9:0]  cpu_wait;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   typedef struct {logic v; logic [7:0] d;} pix_t;
   typedef struct {logic rd; logic [7:0] d;} cpu_t;

   pix_t pix_q[$];
   cpu_t cpu_q[$];
   logic [7:0] ram  [0:65535];
   logic [7:0] gold [0:65535];
   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int ack_cnt = 0;

   always #5 vga_clk = ~vga_clk;

   framebuffer_arbiter dut (
      .vga_clk   (vga_clk),
      .rst       (rst),
      .vga_fetch (vga_fetch),
      .vga_addr  (vga_addr),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .cpu_wait  (cpu_wait),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always @(posedge vga_clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                             input logic [7:0] exp);
      int n;
      cpu_t e;
      e.rd = !we;
      e.d  = exp;
      @(posedge vga_clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      cpu_q.push_back(e);
      @(negedge vga_clk);
      chk("issue_we", mem_we, we);
      chk("issue_addr", mem_addr, addr);
      n = 0;
      while (!cpu_ack && n < 20) begin
         @(negedge vga_clk);
         n++;
      end
      chk("ack_latency", n, 1);
      if (we) gold[addr] = wdata;
      @(posedge vga_clk); #1;
      cpu_req = 1'b0;
   endtask

   task automatic starved_read(input logic [15:0] addr, input logic [7:0] exp,
                               input int cycles, input logic [9:0] exp_wait);
      int acks0;
      cpu_t e;
      e.rd = 1'b1;
      e.d  = exp;
      @(posedge vga_clk); #1;
      acks0 = ack_cnt;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
      vga_fetch = 1'b1; vga_addr = 16'h0200;
      cpu_q.push_back(e);
      for (int i = 1; i <= cycles; i++) begin
         @(posedge vga_clk); #1;
         vga_addr  = 16'h0200 + 16'(i % 256);
         vga_fetch = (i < cycles);
      end
      @(negedge vga_clk);
      chk("starve_no_ack", ack_cnt - acks0, 0);
      chk("starve_wait", cpu_wait, exp_wait);
      chk("starve_issue_addr", mem_addr, addr);
      @(negedge vga_clk);
      chk("starve_ack", cpu_ack, 1);
      @(posedge vga_clk); #1;
      cpu_req = 1'b0;
   endtask

   initial begin
      int we0;
      for (int i = 0; i < 65536; i++) begin
         ram[i]  = 8'h00;
         gold[i] = 8'h00;
      end
      for (int i = 0; i < 256; i++) begin
         ram[16'h0200 + i]  = 8'(i) ^ 8'h5A;
         gold[16'h0200 + i] = 8'(i) ^ 8'h5A;
      end
      rst = 1'b1; vga_fetch = 1'b0; vga_addr = 16'h0000;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'hEE;

      fork
         forever begin
            pix_t p;
            @(posedge vga_clk);
            p.v = !rst && vga_fetch;
            p.d = p.v ? gold[vga_addr] : 8'h00;
            pix_q.push_back(p);
         end
         forever begin
            @(negedge vga_clk);
            if (mem_we === 1'b1) we_cnt++;
            chk("we_vs_fetch", mem_we & vga_fetch, 0);
            if (pix_q.size() > 0) begin
               pix_t p;
               p = pix_q.pop_front();
               chk("pix_valid", pix_valid, p.v);
               chk("pix_data", pix_data, p.d);
            end
            if (cpu_ack === 1'b1) begin
               ack_cnt++;
               if (cpu_q.size() == 0) begin
                  chk("unexpected_ack", 1, 0);
               end else begin
                  cpu_t c;
                  c = cpu_q.pop_front();
                  if (c.rd) chk("cpu_rdata", cpu_rdata, c.d);
               end
            end
         end
      join_none

      // reset state, with a write request held to prove the strobe is gated
      @(negedge vga_clk);
      chk("rst_pix_data", pix_data, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_cpu_wait", cpu_wait, 0);
      chk("rst_mem_we", mem_we, 0);
      @(posedge vga_clk); #1;
      cpu_req = 1'b0;
      @(posedge vga_clk); #1;
      rst = 1'b0;

      // test 1: reset lands in RESP
      @(posedge vga_clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h33;
      @(posedge vga_clk); #1;
      rst = 1'b1;
      @(negedge vga_clk);
      chk("midresp_ack", cpu_ack, 0);
      chk("midresp_mem_we", mem_we, 0);
      @(posedge vga_clk); #1;
      cpu_req = 1'b0;
      @(negedge vga_clk);
      chk("midresp_ack2", cpu_ack, 0);
      chk("midresp_wait", cpu_wait, 0);
      @(posedge vga_clk); #1;
      rst = 1'b0;
      @(negedge vga_clk);
      chk("post_rst_ack", cpu_ack, 0);

      // test 2: writes then reads with the display idle
      we0 = we_cnt;
      cpu_access(1'b1, 16'h1234, 8'hA5, 8'h00);
      chk("one_we_pulse", we_cnt - we0, 1);
      cpu_access(1'b0, 16'h1234, 8'h00, 8'hA5);
      cpu_access(1'b1, 16'hFFFF, 8'hC3, 8'h00);
      cpu_access(1'b1, 16'h0000, 8'h3C, 8'h00);
      cpu_access(1'b0, 16'hFFFF, 8'h00, 8'hC3);
      cpu_access(1'b0, 16'h0000, 8'h00, 8'h3C);
      chk("rdata_held", cpu_rdata, 8'h3C);

      // test 3: starved for 256 cycles
      starved_read(16'h1234, 8'hA5, 256, 10'd256);

      // test 4: display fetch of a preloaded pixel, then a blank cycle
      @(posedge vga_clk); #1;
      vga_fetch = 1'b1; vga_addr = 16'h0203;
      @(posedge vga_clk); #1;
      vga_fetch = 1'b0;
      @(negedge vga_clk);
      chk("pix_0203_data", pix_data, 8'h59);
      chk("pix_0203_valid", pix_valid, 1);
      @(negedge vga_clk);
      chk("pix_blank_data", pix_data, 0);
      chk("pix_blank_valid", pix_valid, 0);

      // test 5: wait counter saturates
      starved_read(16'h0203, 8'h59, 2000, 10'd1023);

      // test 6: request abandoned before issue
      we0 = we_cnt;
      @(posedge vga_clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'h77;
      vga_fetch = 1'b1; vga_addr = 16'h0205;
      repeat (5) @(posedge vga_clk);
      #1;
      cpu_req = 1'b0;
      @(negedge vga_clk);
      chk("abandon_wait5", cpu_wait, 5);
      @(negedge vga_clk);
      chk("abandon_wait0", cpu_wait, 0);
      @(posedge vga_clk); #1;
      vga_fetch = 1'b0;
      repeat (4) @(negedge vga_clk);
      chk("abandon_no_we", we_cnt - we0, 0);
      chk("abandon_ram", ram[16'h0020], 8'h00);

      repeat (3) @(negedge vga_clk);
      chk("cpu_queue_empty", cpu_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
